lfsr_param: RTL

Parametrised LFSR engine for pseudo-random bit and word generation. It is the generalised successor of the fixed 8-bit seeded LFSR. It adds:
- configurable width and tap mask
- Fibonacci or Galois structure
- a step enable
- synchronous seed load with zero-seed protection
- lock-up recovery
- a period counter that reports sequence length on wrap

It sits between seed/control logic and consumers of the serial bit or parallel state.

---
 rtl/lfsr_param_if.sv | 58 +++++
 rtl/lfsr_param.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_param_if.sv
// -----------------------------------------------------------------------------
// lfsr_param_if
//   Control and observation bundle for the lfsr_param engine.
//
//   Signals (WIDTH = state width):
//     en           advance the LFSR one step this cycle
//     load         load seed this cycle (wins over en)
//     seed         seed value, sampled when load=1
//     state_o      current registered LFSR state
//     out_bit      serial output bit (a bit-select of state_o)
//     wrap         one-cycle pulse when the sequence returns to its anchor
//     period       step count of the last completed cycle
//     period_valid period holds a measured value
//     lock_err     one-cycle pulse on all-zero state recovery
//
//   Modports:
//     master  seed/control side (drives en/load/seed, observes the rest)
//     slave   the LFSR engine itself
// -----------------------------------------------------------------------------
interface lfsr_param_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] state_o;
  logic             out_bit;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             lock_err;

  modport master (
    output en,
    output load,
    output seed,
    input  state_o,
    input  out_bit,
    input  wrap,
    input  period,
    input  period_valid,
    input  lock_err
  );

  modport slave (
    input  en,
    input  load,
    input  seed,
    output state_o,
    output out_bit,
    output wrap,
    output period,
    output period_valid,
    output lock_err
  );

endinterface : lfsr_param_if

// File: rtl/lfsr_param.sv
// -----------------------------------------------------------------------------
// lfsr_param
//   Parametrised LFSR engine producing a serial pseudo-random bit and the
//   parallel state word. Supports Fibonacci (shift left, feedback into bit 0)
//   and Galois (shift right, taps XORed in when bit 0 falls out) structures,
//   synchronous seed load with zero-seed protection, all-zero lock-up
//   recovery, and a period counter that reports the orbit length each time
//   the sequence returns to its anchor (the last seed / reset value).
//
//   Parameters:
//     WIDTH        state width, 3..32
//     TAPS         feedback tap mask; bit i set means state bit i is a tap
//     GALOIS       0 = Fibonacci, 1 = Galois
//     DEFAULT_SEED nonzero state used at reset, zero-seed load and recovery
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   lfsr_param_if.slave (en, load, seed in; state/status out)
//
//   Every output is a register or a bit-select of one; no input reaches an
//   output combinationally.
// -----------------------------------------------------------------------------
module lfsr_param #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter bit               GALOIS       = 1'b0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_param_if.slave  bus
);

  // Per-cycle operation, in strict priority order.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_RECOVER
  } op_e;

  // Counter ceiling. A valid nonzero orbit is at most 2^WIDTH-1 states long,
  // so cnt tops out at 2^WIDTH-2 before the wrap clears it. Saturating here
  // only matters for orbits that never revisit the anchor (non-invertible
  // tap masks) and keeps cnt from silently rolling over in that case.
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] anchor_q, anchor_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
  logic             wrap_q,   wrap_d;
  logic             lock_q,   lock_d;

  op_e              op;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] seed_val;

  // One LFSR step from state s.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (GALOIS) begin
      // Bit 0 leaves the register; when it is 1 the tap mask is folded in.
      r = (s >> 1) ^ (s[0] ? TAPS : '0);
    end else begin
      // Parity of the tapped bits enters at the bottom.
      r = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    return r;
  endfunction

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    op       = OP_HOLD;
    state_d  = state_q;
    anchor_d = anchor_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    wrap_d   = 1'b0;
    lock_d   = 1'b0;

    step_val = lfsr_step(state_q);
    seed_val = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;

    // All-zero state is checked before load/en: it is a fixed point of both
    // structures, so it must be escaped no matter what the controls say.
    if (state_q == '0) begin
      op = OP_RECOVER;
    end else if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.en) begin
      op = OP_STEP;
    end

    case (op)
      OP_RECOVER: begin
        state_d  = DEFAULT_SEED;
        anchor_d = DEFAULT_SEED;
        cnt_d    = '0;
        pvalid_d = 1'b0;
        lock_d   = 1'b1;
      end
      OP_LOAD: begin
        // The loaded value becomes the new anchor; any wrap that a step
        // would have produced this cycle is discarded.
        state_d  = seed_val;
        anchor_d = seed_val;
        cnt_d    = '0;
        pvalid_d = 1'b0;
      end
      OP_STEP: begin
        state_d = step_val;
        if (step_val == anchor_q) begin
          // cnt counts steps already taken in this lap; this one closes it.
          period_d = cnt_q + 1'b1;
          pvalid_d = 1'b1;
          wrap_d   = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Hold: state, anchor and cnt keep their values; pulses stay low.
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DEFAULT_SEED;
      anchor_q <= DEFAULT_SEED;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      anchor_q <= anchor_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      wrap_q   <= wrap_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.state_o      = state_q;
  assign bus.out_bit      = GALOIS ? state_q[0] : state_q[WIDTH-1];
  assign bus.wrap         = wrap_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pvalid_q;
  assign bus.lock_err     = lock_q;

endmodule : lfsr_param
